// File: rtl/wasm_loader.sv
`default_nettype none
// wasm_loader: walks a mapped WebAssembly ROM at boot, locates function 0's first opcode
// and hands the memory bus to the CPU once parsing succeeds.
module wasm_loader #(
    parameter logic [31:0] ROM_BASE = 32'd0,
    parameter logic [31:0] ROM_SIZE = 32'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    output logic        mem_read_en,
    input  logic [7:0]  mem_data_out,
    input  logic        mem_ready,
    output logic        mem_access,
    output logic        rom_mapped,
    output logic [31:0] first_instruction,
    output logic [31:0] func_end,
    output logic [31:0] local_count,
    output logic        error,
    output logic [2:0]  error_code
);
    localparam logic [32:0] ROM_END = {1'b0, ROM_BASE} + {1'b0, ROM_SIZE};

    typedef enum logic [3:0] {
        MAGIC, VERSION, SEC_ID, SEC_SIZE, SKIP, CODE_COUNT,
        BODY_SIZE, DECL_COUNT, LOCAL_N, LOCAL_TYPE, DONE, ERROR
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [2:0]  leb_idx;
    logic [31:0] leb_acc;
    logic [31:0] decls_left;
    logic [31:0] body_end;
    logic [31:0] local_sum;
    logic [7:0]  sec_id;

    logic        handshake;
    logic        reading;
    logic        leb_state;
    logic        leb_last;
    logic        leb_ovf;
    logic [4:0]  leb_shamt;
    logic [31:0] leb_val;
    logic [31:0] addr_next;
    logic [32:0] skip_end;
    logic [7:0]  expect_byte;

    assign handshake  = mem_read_en && mem_ready;
    assign addr_next  = mem_addr + 32'd1;
    assign reading    = (state != SKIP) && (state != DONE) && (state != ERROR);
    assign leb_state  = state inside {SEC_SIZE, CODE_COUNT, BODY_SIZE, DECL_COUNT, LOCAL_N};
    assign mem_access = !rom_mapped;

    // leb_acc holds the finished value after the last byte, so a fresh LEB starts from zero
    assign leb_shamt = 5'(leb_idx) * 5'd7;
    assign leb_val   = ((leb_idx == 3'd0) ? 32'd0 : leb_acc)
                     | (32'(mem_data_out[6:0]) << leb_shamt);
    assign leb_ovf   = (leb_idx == 3'd4) && (mem_data_out[7] || (mem_data_out[6:4] != 3'd0));
    assign leb_last  = !mem_data_out[7];
    assign skip_end  = {1'b0, mem_addr} + {1'b0, leb_acc};

    always_comb begin
        expect_byte = 8'h00;
        if (state == MAGIC) begin
            case (byte_idx)
                2'd0:    expect_byte = 8'h00;
                2'd1:    expect_byte = 8'h61;
                2'd2:    expect_byte = 8'h73;
                default: expect_byte = 8'h6D;
            endcase
        end else if (byte_idx == 2'd0) begin
            expect_byte = 8'h01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= MAGIC;
            mem_addr          <= ROM_BASE;
            mem_read_en       <= 1'b0;
            byte_idx          <= 2'd0;
            leb_idx           <= 3'd0;
            leb_acc           <= 32'd0;
            decls_left        <= 32'd0;
            body_end          <= 32'd0;
            local_sum         <= 32'd0;
            sec_id            <= 8'd0;
            rom_mapped        <= 1'b0;
            first_instruction <= 32'd0;
            func_end          <= 32'd0;
            local_count       <= 32'd0;
            error             <= 1'b0;
            error_code        <= 3'd0;
        end else if (state == SKIP) begin
            if (skip_end > ROM_END) begin
                state      <= ERROR;
                error      <= 1'b1;
                error_code <= 3'd5;
            end else begin
                mem_addr <= skip_end[31:0];
                state    <= SEC_ID;
            end
        end else if (reading && !mem_read_en) begin
            // running off the end while looking for a section id means there is no code section
            if ({1'b0, mem_addr} >= ROM_END) begin
                state      <= ERROR;
                error      <= 1'b1;
                error_code <= (state == SEC_ID) ? 3'd3 : 3'd5;
            end else begin
                mem_read_en <= 1'b1;
            end
        end else if (handshake) begin
            mem_read_en <= 1'b0;
            mem_addr    <= addr_next;
            if (leb_state) begin
                leb_acc <= leb_val;
                leb_idx <= leb_last ? 3'd0 : leb_idx + 3'd1;
            end
            if (leb_state && leb_ovf) begin
                state      <= ERROR;
                error      <= 1'b1;
                error_code <= 3'd4;
            end else begin
                case (state)
                    MAGIC, VERSION: begin
                        if (mem_data_out != expect_byte) begin
                            state      <= ERROR;
                            error      <= 1'b1;
                            error_code <= (state == MAGIC) ? 3'd1 : 3'd2;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3)
                                state <= (state == MAGIC) ? VERSION : SEC_ID;
                        end
                    end
                    SEC_ID: begin
                        sec_id <= mem_data_out;
                        state  <= SEC_SIZE;
                    end
                    SEC_SIZE: begin
                        if (leb_last)
                            state <= (sec_id == 8'h0A) ? CODE_COUNT : SKIP;
                    end
                    CODE_COUNT: begin
                        if (leb_last) begin
                            if (leb_val == 32'd0) begin
                                state      <= ERROR;
                                error      <= 1'b1;
                                error_code <= 3'd6;
                            end else begin
                                state <= BODY_SIZE;
                            end
                        end
                    end
                    BODY_SIZE: begin
                        if (leb_last) begin
                            body_end <= addr_next + leb_val;
                            state    <= DECL_COUNT;
                        end
                    end
                    DECL_COUNT: begin
                        if (leb_last) begin
                            if (leb_val == 32'd0) begin
                                state             <= DONE;
                                rom_mapped        <= 1'b1;
                                first_instruction <= addr_next;
                                func_end          <= body_end;
                                local_count       <= local_sum;
                            end else begin
                                decls_left <= leb_val;
                                state      <= LOCAL_N;
                            end
                        end
                    end
                    LOCAL_N: begin
                        if (leb_last) begin
                            local_sum <= local_sum + leb_val;
                            state     <= LOCAL_TYPE;
                        end
                    end
                    LOCAL_TYPE: begin
                        decls_left <= decls_left - 32'd1;
                        if (decls_left == 32'd1) begin
                            state             <= DONE;
                            rom_mapped        <= 1'b1;
                            first_instruction <= addr_next;
                            func_end          <= body_end;
                            local_count       <= local_sum;
                        end else begin
                            state <= LOCAL_N;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
